vic_int_status: RTL
===================

# vic_int_status

Interrupt status stage of the vectored interrupt controller. It feeds the FIQ and IRQ request units. It synchronises 32 raw interrupt sources, merges them with software interrupts, and applies the enable and select registers. It then drives registered `FIQStatus` and `IRQStatus` vectors downstream. Software programs it through a simple single-cycle register port.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of the raw-source synchroniser. Legal values are 2..3.
- `clk  in  1`: the single clock.
- `rst  in  1`: reset, asynchronous and active-high.
- `VICIntSource  in  32`: raw level interrupt inputs. Asynchronous to `clk`.
- `reg_wr  in  1`: register write strobe.
- `reg_rd  in  1`: register read strobe.
- `reg_addr  in  3`: word index of the register.
- `reg_wdata  in  32`: write data.
- `reg_rdata  out  32`: read data.
- `reg_rvalid  out  1`: read data valid, one-cycle pulse.
- `FIQStatus  out  32`: enabled interrupts selected as FIQ. Registered.
- `IRQStatus  out  32`: enabled interrupts selected as IRQ. Registered.

## Operation
- Register map, by `reg_addr`:
  - 0 IRQStatus: read-only.
  - 1 FIQStatus: read-only.
  - 2 RawIntr: read-only. Value is synced sources OR SoftInt.
  - 3 IntSelect: read/write. Bit = 1 routes that source to FIQ.
  - 4 IntEnable: read returns the enable register. Writing 1s sets the corresponding bits.
  - 5 IntEnClear: write-only. Writing 1s clears enable bits.
  - 6 SoftInt: read returns SoftInt. Writing 1s sets bits.
  - 7 SoftIntClear: write-only. Writing 1s clears SoftInt bits.
- Writing 0 bits to any set or clear register has no effect.
- Writes to read-only registers are ignored.
- Reads of write-only registers return 0.
- `raw = sync(VICIntSource) | SoftInt`.
- `en = raw & IntEnable`.
- Next-state values:
  - `FIQStatus <= en & IntSelect`.
  - `IRQStatus <= en & ~IntSelect`.
- A single bit never appears in both status outputs.
- If `reg_wr` and `reg_rd` are asserted in the same cycle, both are performed. The read returns the pre-write value of the register.
- Every bit is independent. No priority logic exists in this block.

## Timing
- Reset value is 0 for every output and every internal register: `reg_rdata`, `reg_rvalid`, `FIQStatus`, `IRQStatus`, IntSelect, IntEnable, SoftInt and the synchroniser flops.
- Source latency: a change on `VICIntSource` sampled at edge N is visible on the status outputs after edge N+SYNC_STAGES. That is SYNC_STAGES+1 clock edges in total.
- Write latency: a register written at edge N updates at edge N. The status outputs reflect the new value after edge N+1.
- Read latency is one cycle:
  - `reg_rd` sampled at edge N drives `reg_rdata` and `reg_rvalid`=1 after edge N.
  - `reg_rvalid` returns to 0 on the next edge unless `reg_rd` is held. Back-to-back reads are allowed at one per cycle.
  - `reg_rdata` holds its last value while `reg_rvalid`=0.
- Pulses on `VICIntSource` shorter than one clock period may be lost. Sources must be held until software services them.
- Reset asserted mid-operation:
  - Everything clears asynchronously.
  - An in-flight read returns no `reg_rvalid`.
  - The status outputs drop to 0 immediately.

## Structure
- Add to `defs.v`:
  - Register index constants `VIC_ADDR_IRQSTAT` through `VIC_ADDR_SOFTCLR` (values 0..7).
  - `VIC_NUM_INT` = 32.
- Sub-module `vic_sync`: a parameterised N-flop vector synchroniser (width, stages) with async active-high reset. Instantiate it once for `VICIntSource`.
- The remainder of the block is flat: register file, combinational merge, status flops and read mux.

## Test plan
- Reset: assert `rst` mid-run with IntEnable = `0xFFFFFFFF`.
  - Required: all outputs are 0 immediately.
  - Required: reading IntEnable after release returns 0.
- Routing:
  - Setup: write IntEnable = `0xFFFFFFFF` and IntSelect = `0x4A000000`, then drive `VICIntSource` = `0x4A0000A4`.
  - Required: after SYNC_STAGES+1 edges, `FIQStatus` = `0x4A000000` and `IRQStatus` = `0x000000A4`.
- Enable set/clear:
  - Write IntEnable = `0x000000F0`, then IntEnClear = `0x00000030`.
  - Required: reading IntEnable returns `0x000000C0`.
  - Required: with all sources high and IntSelect = 0, `IRQStatus` = `0x000000C0`.
- Software interrupt:
  - Sources at 0, IntEnable = `0xFFFFFFFF`, IntSelect = `0x1`. Write SoftInt = `0x3`.
  - Required: after 2 edges, `FIQStatus` = `0x1` and `IRQStatus` = `0x2`.
  - Then write SoftIntClear = `0x1`. Required: `FIQStatus` = 0 and RawIntr = `0x2`.
- Read port behaviour:
  - Back-to-back reads of addresses 2, 3, 4 give three consecutive `reg_rvalid` pulses with the matching data.
  - A simultaneous read and write of IntSelect returns the old value.
  - A read of address 5 returns 0.
- Source toggling: toggle `VICIntSource` between `0x4A0000A4` and 0 with a 10/20 ns pattern against a 10 ns clock.
  - Required: the status outputs follow the pattern, delayed by exactly SYNC_STAGES+1 cycles.
  - Required: `FIQStatus & IRQStatus` = 0 at every cycle.

Source files
------------

// File: rtl/vic_int_status_pkg.sv
// -----------------------------------------------------------------------------
// vic_int_status_pkg
// Shared constants and helpers for the VIC interrupt status stage.
//   VIC_NUM_INT        : number of interrupt sources / status vector width
//   VIC_ADDR_*         : register word indices on the reg_addr port
//   vic_set_clr()      : write-1-to-set / write-1-to-clear merge helper
// -----------------------------------------------------------------------------
package vic_int_status_pkg;

    localparam int VIC_NUM_INT = 32;

    localparam logic [2:0] VIC_ADDR_IRQSTAT  = 3'd0;  // read-only
    localparam logic [2:0] VIC_ADDR_FIQSTAT  = 3'd1;  // read-only
    localparam logic [2:0] VIC_ADDR_RAWINTR  = 3'd2;  // read-only
    localparam logic [2:0] VIC_ADDR_INTSEL   = 3'd3;  // read/write
    localparam logic [2:0] VIC_ADDR_INTEN    = 3'd4;  // read / write-1-to-set
    localparam logic [2:0] VIC_ADDR_INTENCLR = 3'd5;  // write-1-to-clear
    localparam logic [2:0] VIC_ADDR_SOFTINT  = 3'd6;  // read / write-1-to-set
    localparam logic [2:0] VIC_ADDR_SOFTCLR  = 3'd7;  // write-1-to-clear

    // Only one of set/clr is ever non-zero in a cycle (single address port),
    // so the ordering of set and clear here never matters in practice.
    function automatic logic [VIC_NUM_INT-1:0] vic_set_clr(
        input logic [VIC_NUM_INT-1:0] cur,
        input logic [VIC_NUM_INT-1:0] set_mask,
        input logic [VIC_NUM_INT-1:0] clr_mask
    );
        return (cur | set_mask) & ~clr_mask;
    endfunction

endpackage

// File: rtl/vic_sync.sv
// -----------------------------------------------------------------------------
// vic_sync
// N-flop vector synchroniser for level signals crossing into clk.
// Each bit is synchronised independently; no multi-bit coherency is implied.
// Ports:
//   clk    : destination clock
//   rst    : asynchronous active-high reset, clears every stage
//   i_data : asynchronous input vector
//   o_data : synchronised output (last stage)
// Parameters:
//   WIDTH  : vector width
//   STAGES : number of flops in the chain (>= 2)
// -----------------------------------------------------------------------------
module vic_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_sync [STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_sync[gi] <= '0;
                    end else begin
                        r_sync[gi] <= i_data;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_sync[gi] <= '0;
                    end else begin
                        r_sync[gi] <= r_sync[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign o_data = r_sync[STAGES-1];

endmodule

// File: rtl/vic_int_status.sv
// -----------------------------------------------------------------------------
// vic_int_status
// Interrupt status stage of the vectored interrupt controller. Synchronises
// the raw sources, ORs in software interrupts, masks with IntEnable and
// routes each enabled bit to either FIQStatus or IRQStatus via IntSelect.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   VICIntSource  : raw level interrupt sources (asynchronous to clk)
//   reg_wr/reg_rd : single-cycle register write / read strobes
//   reg_addr      : register word index (see VIC_ADDR_* in the package)
//   reg_wdata     : write data
//   reg_rdata     : registered read data, holds between reads
//   reg_rvalid    : one-cycle read-valid pulse
//   FIQStatus     : registered enabled sources routed to FIQ
//   IRQStatus     : registered enabled sources routed to IRQ
// Parameters:
//   SYNC_STAGES   : synchroniser depth, legal range 2..3
// -----------------------------------------------------------------------------
module vic_int_status
    import vic_int_status_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [VIC_NUM_INT-1:0] VICIntSource,
    input  logic                   reg_wr,
    input  logic                   reg_rd,
    input  logic [2:0]             reg_addr,
    input  logic [VIC_NUM_INT-1:0] reg_wdata,
    output logic [VIC_NUM_INT-1:0] reg_rdata,
    output logic                   reg_rvalid,
    output logic [VIC_NUM_INT-1:0] FIQStatus,
    output logic [VIC_NUM_INT-1:0] IRQStatus
);

    // -------------------------------------------------------------------------
    // Source synchroniser
    // -------------------------------------------------------------------------
    logic [VIC_NUM_INT-1:0] w_src_sync;

    vic_sync #(
        .WIDTH  (VIC_NUM_INT),
        .STAGES (SYNC_STAGES)
    ) u_src_sync (
        .clk    (clk),
        .rst    (rst),
        .i_data (VICIntSource),
        .o_data (w_src_sync)
    );

    // -------------------------------------------------------------------------
    // Register file
    // -------------------------------------------------------------------------
    logic [VIC_NUM_INT-1:0] r_int_select;
    logic [VIC_NUM_INT-1:0] r_int_enable;
    logic [VIC_NUM_INT-1:0] r_soft_int;

    logic [VIC_NUM_INT-1:0] w_int_select_next;
    logic [VIC_NUM_INT-1:0] w_int_enable_next;
    logic [VIC_NUM_INT-1:0] w_soft_int_next;

    logic [VIC_NUM_INT-1:0] w_en_set;
    logic [VIC_NUM_INT-1:0] w_en_clr;
    logic [VIC_NUM_INT-1:0] w_soft_set;
    logic [VIC_NUM_INT-1:0] w_soft_clr;

    // Write decode turns each set/clear register into a mask; writes to the
    // read-only addresses simply produce no mask and are dropped.
    always_comb begin
        w_en_set          = '0;
        w_en_clr          = '0;
        w_soft_set        = '0;
        w_soft_clr        = '0;
        w_int_select_next = r_int_select;
        if (reg_wr) begin
            case (reg_addr)
                VIC_ADDR_INTSEL:   w_int_select_next = reg_wdata;
                VIC_ADDR_INTEN:    w_en_set          = reg_wdata;
                VIC_ADDR_INTENCLR: w_en_clr          = reg_wdata;
                VIC_ADDR_SOFTINT:  w_soft_set        = reg_wdata;
                VIC_ADDR_SOFTCLR:  w_soft_clr        = reg_wdata;
                default:           ;
            endcase
        end
        w_int_enable_next = vic_set_clr(r_int_enable, w_en_set, w_en_clr);
        w_soft_int_next   = vic_set_clr(r_soft_int, w_soft_set, w_soft_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_int_select <= '0;
            r_int_enable <= '0;
            r_soft_int   <= '0;
        end else begin
            r_int_select <= w_int_select_next;
            r_int_enable <= w_int_enable_next;
            r_soft_int   <= w_soft_int_next;
        end
    end

    // -------------------------------------------------------------------------
    // Merge and status flops (bitwise, no priority between sources)
    // -------------------------------------------------------------------------
    logic [VIC_NUM_INT-1:0] w_raw;
    logic [VIC_NUM_INT-1:0] w_en;
    logic [VIC_NUM_INT-1:0] w_fiq_next;
    logic [VIC_NUM_INT-1:0] w_irq_next;
    logic [VIC_NUM_INT-1:0] r_fiq_status;
    logic [VIC_NUM_INT-1:0] r_irq_status;

    assign w_raw = w_src_sync | r_soft_int;
    assign w_en  = w_raw & r_int_enable;

    // Each bit is routed to exactly one of the two outputs by IntSelect, so a
    // bit can never be set in both status vectors at once.
    generate
        for (genvar gi = 0; gi < VIC_NUM_INT; gi++) begin : g_route
            assign w_fiq_next[gi] = w_en[gi] &  r_int_select[gi];
            assign w_irq_next[gi] = w_en[gi] & ~r_int_select[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fiq_status <= '0;
            r_irq_status <= '0;
        end else begin
            r_fiq_status <= w_fiq_next;
            r_irq_status <= w_irq_next;
        end
    end

    assign FIQStatus = r_fiq_status;
    assign IRQStatus = r_irq_status;

    // -------------------------------------------------------------------------
    // Read port: mux uses current (pre-write) register values, so a read and
    // write of the same register in one cycle returns the old contents.
    // -------------------------------------------------------------------------
    logic [VIC_NUM_INT-1:0] w_rdata_mux;
    logic [VIC_NUM_INT-1:0] r_rdata;
    logic                   r_rvalid;

    always_comb begin
        w_rdata_mux = '0;
        case (reg_addr)
            VIC_ADDR_IRQSTAT: w_rdata_mux = r_irq_status;
            VIC_ADDR_FIQSTAT: w_rdata_mux = r_fiq_status;
            VIC_ADDR_RAWINTR: w_rdata_mux = w_raw;
            VIC_ADDR_INTSEL:  w_rdata_mux = r_int_select;
            VIC_ADDR_INTEN:   w_rdata_mux = r_int_enable;
            VIC_ADDR_SOFTINT: w_rdata_mux = r_soft_int;
            default:          w_rdata_mux = '0;  // write-only registers
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= reg_rd;
            if (reg_rd) begin
                r_rdata <= w_rdata_mux;
            end
        end
    end

    assign reg_rdata  = r_rdata;
    assign reg_rvalid = r_rvalid;

endmodule
